// File: rtl/tb_boot_sequencer_pkg.sv
// Shared definitions for the testbench boot sequencer.
// Holds the FSM state type, DCR address map, write count and the order in which the
// per-domain resets are released. The ERROR state exists only when TB_BOOT_TIMEOUT_EN
// is defined.
package tb_boot_sequencer_pkg;

  localparam int unsigned VX_DCR_ADDR_WIDTH = 12;
  localparam int unsigned VX_DCR_DATA_WIDTH = 32;

  localparam logic [VX_DCR_ADDR_WIDTH-1:0] VX_DCR_BASE_STARTUP_ADDR0 = 12'h001;
  localparam logic [VX_DCR_ADDR_WIDTH-1:0] VX_DCR_BASE_STARTUP_ADDR1 = 12'h002;
  localparam logic [VX_DCR_ADDR_WIDTH-1:0] VX_DCR_BASE_STARTUP_ARG0  = 12'h003;
  localparam logic [VX_DCR_ADDR_WIDTH-1:0] VX_DCR_BASE_STARTUP_ARG1  = 12'h004;
  localparam logic [VX_DCR_ADDR_WIDTH-1:0] VX_DCR_BASE_MPM_CLASS     = 12'h005;

  localparam int unsigned TB_BOOT_NUM_DCR = 5;
  localparam int unsigned TB_BOOT_NUM_DOM = 5;

  // Bit positions in the domain reset vector, also the release order.
  localparam logic [2:0] RST_IDX_MEM_ARB = 3'd0;
  localparam logic [2:0] RST_IDX_ICACHE  = 3'd1;
  localparam logic [2:0] RST_IDX_DCACHE  = 3'd2;
  localparam logic [2:0] RST_IDX_GBAR    = 3'd3;
  localparam logic [2:0] RST_IDX_CORE    = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StLoad,
    StDcr,
    StRelease,
`ifdef TB_BOOT_TIMEOUT_EN
    StRun,
    StError
`else
    StRun
`endif
  } tb_boot_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tb_boot_dcr_rom.sv
// Startup DCR write table.
// Maps a write index to the {address, data} pair, taking data from the startup
// values captured at boot request. Indices past the table return zeros.
//   idx_i          : write index (0..TB_BOOT_NUM_DCR-1)
//   startup_addr_i : captured kernel entry PC
//   startup_arg_i  : captured kernel argument pointer
//   addr_o, data_o : DCR address and data for this index
module tb_boot_dcr_rom
  import tb_boot_sequencer_pkg::*;
(
  input  logic [2:0]                   idx_i,
  input  logic [63:0]                  startup_addr_i,
  input  logic [63:0]                  startup_arg_i,
  output logic [VX_DCR_ADDR_WIDTH-1:0] addr_o,
  output logic [VX_DCR_DATA_WIDTH-1:0] data_o
);

  always_comb begin
    addr_o = '0;
    data_o = '0;
    unique case (idx_i)
      3'd0: begin
        addr_o = VX_DCR_BASE_STARTUP_ADDR0;
        data_o = startup_addr_i[31:0];
      end
      3'd1: begin
        addr_o = VX_DCR_BASE_STARTUP_ADDR1;
        data_o = startup_addr_i[63:32];
      end
      3'd2: begin
        addr_o = VX_DCR_BASE_STARTUP_ARG0;
        data_o = startup_arg_i[31:0];
      end
      3'd3: begin
        addr_o = VX_DCR_BASE_STARTUP_ARG1;
        data_o = startup_arg_i[63:32];
      end
      3'd4: begin
        addr_o = VX_DCR_BASE_MPM_CLASS;
        data_o = '0;
      end
      default: begin
        addr_o = '0;
        data_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/tb_boot_sequencer.sv
// Testbench boot controller: holds all GPU domains in reset, runs the memory loader,
// writes the startup DCRs, then releases domain resets in a fixed order.
// Optional macro TB_BOOT_TIMEOUT_EN adds a LOAD timeout leading to a sticky ERROR state.
// Ports:
//   clk, reset (async, active high)
//   start, startup_addr, startup_arg  : boot request and captured startup values
//   mem_loader_done                   : loader completion level
//   *_reset                           : seven domain resets (active high)
//   load_mem, start_mem_loader        : loader window and one-cycle kick
//   dcr_write_valid/addr/data         : fire-and-forget DCR write port
//   busy, boot_done, error            : status
// All outputs are registered.
module tb_boot_sequencer
  import tb_boot_sequencer_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned RELEASE_GAP  = 4,
  parameter int unsigned LOAD_TIMEOUT = 100000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [63:0]                  startup_addr,
  input  logic [63:0]                  startup_arg,
  input  logic                         mem_loader_done,
  output logic                         mem_load_reset,
  output logic                         mem_reset,
  output logic                         mem_arb_reset,
  output logic                         icache_reset,
  output logic                         dcache_reset,
  output logic                         gbar_reset,
  output logic                         core_reset,
  output logic                         load_mem,
  output logic                         start_mem_loader,
  output logic                         dcr_write_valid,
  output logic [VX_DCR_ADDR_WIDTH-1:0] dcr_write_addr,
  output logic [VX_DCR_DATA_WIDTH-1:0] dcr_write_data,
  output logic                         busy,
  output logic                         boot_done,
  output logic                         error
);

  localparam int unsigned CntW = $clog2(max_u(RST_CYCLES, RELEASE_GAP)) + 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(RELEASE_GAP - 1);

  tb_boot_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0] dcr_idx_q, dcr_idx_d;
  logic [2:0] rel_idx_q, rel_idx_d;
  logic load_first_q, load_first_d;
  logic [63:0] addr_cap_q, addr_cap_d;
  logic [63:0] arg_cap_q, arg_cap_d;
  logic [TB_BOOT_NUM_DOM-1:0] dom_rst_q, dom_rst_d;
  logic mem_load_reset_q, mem_load_reset_d;
  logic mem_reset_q, mem_reset_d;
  logic load_mem_q, load_mem_d;
  logic start_mem_loader_q, start_mem_loader_d;
  logic dcr_valid_q, dcr_valid_d;
  logic [VX_DCR_ADDR_WIDTH-1:0] dcr_addr_q, dcr_addr_d;
  logic [VX_DCR_DATA_WIDTH-1:0] dcr_data_q, dcr_data_d;
  logic busy_q, busy_d;
  logic boot_done_q, boot_done_d;

  logic [2:0] rom_idx;
  logic [VX_DCR_ADDR_WIDTH-1:0] rom_addr;
  logic [VX_DCR_DATA_WIDTH-1:0] rom_data;

`ifdef TB_BOOT_TIMEOUT_EN
  localparam logic [31:0] LoadLast = 32'(LOAD_TIMEOUT - 1);
  logic [31:0] ld_cnt_q, ld_cnt_d;
  logic error_q, error_d;
`endif

  // The first write is issued on the LOAD->DCR edge, so LOAD always looks up entry 0.
  assign rom_idx = (state_q == StDcr) ? dcr_idx_q : 3'd0;

  tb_boot_dcr_rom u_dcr_rom (
    .idx_i          (rom_idx),
    .startup_addr_i (addr_cap_q),
    .startup_arg_i  (arg_cap_q),
    .addr_o         (rom_addr),
    .data_o         (rom_data)
  );

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    dcr_idx_d          = dcr_idx_q;
    rel_idx_d          = rel_idx_q;
    load_first_d       = load_first_q;
    addr_cap_d         = addr_cap_q;
    arg_cap_d          = arg_cap_q;
    dom_rst_d          = dom_rst_q;
    mem_load_reset_d   = mem_load_reset_q;
    mem_reset_d        = mem_reset_q;
    load_mem_d         = load_mem_q;
    start_mem_loader_d = 1'b0;
    dcr_valid_d        = 1'b0;
    dcr_addr_d         = '0;
    dcr_data_d         = '0;
    busy_d             = busy_q;
    boot_done_d        = boot_done_q;
`ifdef TB_BOOT_TIMEOUT_EN
    ld_cnt_d           = ld_cnt_q;
    error_d            = error_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StHold;
          busy_d     = 1'b1;
          cnt_d      = '0;
          addr_cap_d = startup_addr;
          arg_cap_d  = startup_arg;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d            = StLoad;
          mem_load_reset_d   = 1'b0;
          mem_reset_d        = 1'b0;
          load_mem_d         = 1'b1;
          start_mem_loader_d = 1'b1;
          load_first_d       = 1'b1;
`ifdef TB_BOOT_TIMEOUT_EN
          ld_cnt_d           = '0;
`endif
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      StLoad: begin
        load_first_d = 1'b0;
        // Done is masked in the entry cycle so a level left high from a previous
        // load cannot skip the new one.
        if (!load_first_q && mem_loader_done) begin
          state_d     = StDcr;
          load_mem_d  = 1'b0;
          dcr_valid_d = 1'b1;
          dcr_addr_d  = rom_addr;
          dcr_data_d  = rom_data;
          dcr_idx_d   = 3'd1;
        end
`ifdef TB_BOOT_TIMEOUT_EN
        else if (ld_cnt_q == LoadLast) begin
          state_d          = StError;
          error_d          = 1'b1;
          mem_load_reset_d = 1'b1;
          mem_reset_d      = 1'b1;
          load_mem_d       = 1'b0;
          busy_d           = 1'b0;
        end else begin
          ld_cnt_d = (ld_cnt_q == '1) ? ld_cnt_q : ld_cnt_q + 32'd1;
        end
`endif
      end
      StDcr: begin
        if (dcr_idx_q == 3'(TB_BOOT_NUM_DCR)) begin
          state_d                    = StRelease;
          dom_rst_d[RST_IDX_MEM_ARB] = 1'b0;
          cnt_d                      = '0;
          rel_idx_d                  = RST_IDX_ICACHE;
        end else begin
          dcr_valid_d = 1'b1;
          dcr_addr_d  = rom_addr;
          dcr_data_d  = rom_data;
          dcr_idx_d   = (dcr_idx_q == '1) ? dcr_idx_q : dcr_idx_q + 3'd1;
        end
      end
      StRelease: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (rel_idx_q <= RST_IDX_CORE) begin
            dom_rst_d[rel_idx_q] = 1'b0;
          end
          rel_idx_d = (rel_idx_q == '1) ? rel_idx_q : rel_idx_q + 3'd1;
          if (rel_idx_q == RST_IDX_CORE) begin
            state_d     = StRun;
            boot_done_d = 1'b1;
            busy_d      = 1'b0;
          end
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      StRun: begin
      end
`ifdef TB_BOOT_TIMEOUT_EN
      StError: begin
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= StIdle;
      cnt_q              <= '0;
      dcr_idx_q          <= '0;
      rel_idx_q          <= '0;
      load_first_q       <= 1'b0;
      addr_cap_q         <= '0;
      arg_cap_q          <= '0;
      dom_rst_q          <= '1;
      mem_load_reset_q   <= 1'b1;
      mem_reset_q        <= 1'b1;
      load_mem_q         <= 1'b0;
      start_mem_loader_q <= 1'b0;
      dcr_valid_q        <= 1'b0;
      dcr_addr_q         <= '0;
      dcr_data_q         <= '0;
      busy_q             <= 1'b0;
      boot_done_q        <= 1'b0;
`ifdef TB_BOOT_TIMEOUT_EN
      ld_cnt_q           <= '0;
      error_q            <= 1'b0;
`endif
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      dcr_idx_q          <= dcr_idx_d;
      rel_idx_q          <= rel_idx_d;
      load_first_q       <= load_first_d;
      addr_cap_q         <= addr_cap_d;
      arg_cap_q          <= arg_cap_d;
      dom_rst_q          <= dom_rst_d;
      mem_load_reset_q   <= mem_load_reset_d;
      mem_reset_q        <= mem_reset_d;
      load_mem_q         <= load_mem_d;
      start_mem_loader_q <= start_mem_loader_d;
      dcr_valid_q        <= dcr_valid_d;
      dcr_addr_q         <= dcr_addr_d;
      dcr_data_q         <= dcr_data_d;
      busy_q             <= busy_d;
      boot_done_q        <= boot_done_d;
`ifdef TB_BOOT_TIMEOUT_EN
      ld_cnt_q           <= ld_cnt_d;
      error_q            <= error_d;
`endif
    end
  end

  assign mem_load_reset   = mem_load_reset_q;
  assign mem_reset        = mem_reset_q;
  assign mem_arb_reset    = dom_rst_q[RST_IDX_MEM_ARB];
  assign icache_reset     = dom_rst_q[RST_IDX_ICACHE];
  assign dcache_reset     = dom_rst_q[RST_IDX_DCACHE];
  assign gbar_reset       = dom_rst_q[RST_IDX_GBAR];
  assign core_reset       = dom_rst_q[RST_IDX_CORE];
  assign load_mem         = load_mem_q;
  assign start_mem_loader = start_mem_loader_q;
  assign dcr_write_valid  = dcr_valid_q;
  assign dcr_write_addr   = dcr_addr_q;
  assign dcr_write_data   = dcr_data_q;
  assign busy             = busy_q;
  assign boot_done        = boot_done_q;
`ifdef TB_BOOT_TIMEOUT_EN
  assign error            = error_q;
`else
  assign error            = 1'b0;
`endif

endmodule

// File: tb/tb_tb_boot_sequencer.sv
// Self-checking bench for tb_boot_sequencer. Expected DCR writes are queued when a boot
// is requested and compared by a monitor as the DUT issues them.
module tb_tb_boot_sequencer;

  localparam int unsigned RstCycles  = 8;
  localparam int unsigned ReleaseGap = 4;
  localparam int unsigned LoadTo     = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] startup_addr = '0;
  logic [63:0] startup_arg = '0;
  logic        mem_loader_done = 1'b0;
  logic        mem_load_reset, mem_reset, mem_arb_reset, icache_reset;
  logic        dcache_reset, gbar_reset, core_reset;
  logic        load_mem, start_mem_loader, dcr_write_valid;
  logic [11:0] dcr_write_addr;
  logic [31:0] dcr_write_data;
  logic        busy, boot_done, error;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int writes = 0;
  logic [43:0] exp_q[$];

  always #5 clk = ~clk;

  tb_boot_sequencer #(
    .RST_CYCLES   (RstCycles),
    .RELEASE_GAP  (ReleaseGap),
    .LOAD_TIMEOUT (LoadTo)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .startup_addr     (startup_addr),
    .startup_arg      (startup_arg),
    .mem_loader_done  (mem_loader_done),
    .mem_load_reset   (mem_load_reset),
    .mem_reset        (mem_reset),
    .mem_arb_reset    (mem_arb_reset),
    .icache_reset     (icache_reset),
    .dcache_reset     (dcache_reset),
    .gbar_reset       (gbar_reset),
    .core_reset       (core_reset),
    .load_mem         (load_mem),
    .start_mem_loader (start_mem_loader),
    .dcr_write_valid  (dcr_write_valid),
    .dcr_write_addr   (dcr_write_addr),
    .dcr_write_data   (dcr_write_data),
    .busy             (busy),
    .boot_done        (boot_done),
    .error            (error)
  );

  // Scoreboard monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic [43:0] e;
    #1;
    if (start_mem_loader) pulses++;
    if (dcr_write_valid) begin
      writes++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL dcr_unexpected got=%h_%h want=none", dcr_write_addr, dcr_write_data);
      end else begin
        e = exp_q.pop_front();
        if ({dcr_write_addr, dcr_write_data} !== e) begin
          bad++;
          $display("FAIL dcr_write got=%h_%h want=%h_%h", dcr_write_addr, dcr_write_data,
                   e[43:32], e[31:0]);
        end
      end
    end
  end

  // Tasks sample at +2 after the edge, after the monitor has run.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic request_boot(input logic [63:0] a, input logic [63:0] g);
    startup_addr = a;
    startup_arg  = g;
    start        = 1'b1;
    exp_q.push_back({12'h001, a[31:0]});
    exp_q.push_back({12'h002, a[63:32]});
    exp_q.push_back({12'h003, g[31:0]});
    exp_q.push_back({12'h004, g[63:32]});
    exp_q.push_back({12'h005, 32'h0});
    tick();
    start = 1'b0;
    // Later input changes must not reach the DCR writes.
    startup_addr = ~a;
    startup_arg  = ~g;
  endtask

  task automatic wait_pulse(input string name, output int k);
    bit found = 0;
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (start_mem_loader) begin
        k = i;
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s_loader_pulse got=none want=pulse", name);
    end
  endtask

  task automatic wait_done(input string name, input int limit);
    bit found = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (boot_done) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s_boot_done got=0 want=1", name);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    total++;
    if ({mem_load_reset, mem_reset, mem_arb_reset, icache_reset, dcache_reset, gbar_reset,
         core_reset} !== 7'h7f) begin
      bad++;
      $display("FAIL reset_domains got=%b want=1111111", {mem_load_reset, mem_reset,
               mem_arb_reset, icache_reset, dcache_reset, gbar_reset, core_reset});
    end
    total++;
    if ({load_mem, start_mem_loader, dcr_write_valid, busy, boot_done, error} !== 6'b0) begin
      bad++;
      $display("FAIL reset_status got=%b want=000000", {load_mem, start_mem_loader,
               dcr_write_valid, busy, boot_done, error});
    end
    total++;
    if ({dcr_write_addr, dcr_write_data} !== 44'h0) begin
      bad++;
      $display("FAIL reset_dcr got=%h want=0", {dcr_write_addr, dcr_write_data});
    end
    reset = 1'b0;
  endtask

  task automatic test_nominal;
    int k;
    int fall[5];
    logic [4:0] dom;
    pulses = 0;
    writes = 0;
    repeat (10) tick();
    request_boot(64'h0000_0001_8000_0000, 64'hDEAD_BEEF_0000_0040);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL nom_busy got=%b want=1", busy);
    end
    wait_pulse("nom", k);
    total++;
    if (k != RstCycles) begin
      bad++;
      $display("FAIL nom_hold_len got=%0d want=%0d", k, RstCycles);
    end
    total++;
    if ({mem_load_reset, mem_reset, load_mem, mem_arb_reset} !== 4'b0011) begin
      bad++;
      $display("FAIL nom_load_entry got=%b want=0011",
               {mem_load_reset, mem_reset, load_mem, mem_arb_reset});
    end
    repeat (20) tick();
    mem_loader_done = 1'b1;
    tick();
    total++;
    if ({dcr_write_valid, load_mem} !== 2'b10) begin
      bad++;
      $display("FAIL nom_dcr_entry got=%b want=10", {dcr_write_valid, load_mem});
    end
    mem_loader_done = 1'b0;
    for (int d = 0; d < 5; d++) fall[d] = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      dom = {core_reset, gbar_reset, dcache_reset, icache_reset, mem_arb_reset};
      for (int d = 0; d < 5; d++) if (fall[d] < 0 && dom[d] == 1'b0) fall[d] = i;
      if (boot_done) break;
    end
    // Writes occupy samples 0..4 (sample 0 was the entry check), first release at 5.
    total++;
    if (fall[0] != 5) begin
      bad++;
      $display("FAIL nom_arb_release got=%0d want=5", fall[0]);
    end
    for (int d = 1; d < 5; d++) begin
      total++;
      if (fall[d] - fall[0] != d * ReleaseGap) begin
        bad++;
        $display("FAIL nom_release_gap%0d got=%0d want=%0d", d, fall[d] - fall[0],
                 d * ReleaseGap);
      end
    end
    total++;
    if ({boot_done, busy} !== 2'b10) begin
      bad++;
      $display("FAIL nom_done got=%b want=10", {boot_done, busy});
    end
    total++;
    if (pulses != 1 || writes != 5 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL nom_counts got=p%0d_w%0d_q%0d want=p1_w5_q0", pulses, writes,
               exp_q.size());
    end
    // start in RUN is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    total++;
    if ({boot_done, busy, load_mem, core_reset, mem_reset} !== 5'b10000 || pulses != 1) begin
      bad++;
      $display("FAIL run_ignore_start got=%b_p%0d want=10000_p1",
               {boot_done, busy, load_mem, core_reset, mem_reset}, pulses);
    end
  endtask

  task automatic test_stale_done;
    int k;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulses = 0;
    writes = 0;
    mem_loader_done = 1'b1;
    tick();
    request_boot(64'h1234_5678_9ABC_DEF0, 64'h0F0E_0D0C_0B0A_0908);
    wait_pulse("stale", k);
    start = 1'b1; // ignored in LOAD
    tick();
    start = 1'b0;
    total++;
    if ({load_mem, dcr_write_valid} !== 2'b10) begin
      bad++;
      $display("FAIL stale_load_hold got=%b want=10", {load_mem, dcr_write_valid});
    end
    tick();
    total++;
    if ({load_mem, dcr_write_valid} !== 2'b01) begin
      bad++;
      $display("FAIL stale_dcr_start got=%b want=01", {load_mem, dcr_write_valid});
    end
    wait_done("stale", 60);
    total++;
    if (pulses != 1 || writes != 5 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL stale_counts got=p%0d_w%0d_q%0d want=p1_w5_q0", pulses, writes,
               exp_q.size());
    end
    mem_loader_done = 1'b0;
  endtask

  task automatic test_mid_reset;
    int k;
    bit found = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    request_boot({$urandom, $urandom}, {$urandom, $urandom});
    wait_pulse("mid", k);
    repeat (3) tick();
    mem_loader_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dcr_write_valid) begin
        found = 1;
        break;
      end
    end
    tick();
    tick();
    total++;
    if (!found || dcr_write_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_third_write got=%b want=1", dcr_write_valid);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({dcr_write_valid, start_mem_loader, busy} !== 3'b000 ||
        {mem_load_reset, mem_reset, mem_arb_reset, icache_reset, dcache_reset, gbar_reset,
         core_reset} !== 7'h7f) begin
      bad++;
      $display("FAIL mid_async_reset got=%b_%b want=000_1111111",
               {dcr_write_valid, start_mem_loader, busy}, {mem_load_reset, mem_reset,
               mem_arb_reset, icache_reset, dcache_reset, gbar_reset, core_reset});
    end
    exp_q.delete();
    mem_loader_done = 1'b0;
    tick();
    reset = 1'b0;
    pulses = 0;
    writes = 0;
    request_boot(64'hCAFE_F00D_0000_1000, 64'h0000_0000_0000_2000);
    wait_pulse("mid_restart", k);
    tick();
    mem_loader_done = 1'b1;
    wait_done("mid_restart", 60);
    total++;
    if (pulses != 1 || writes != 5 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL mid_restart_counts got=p%0d_w%0d_q%0d want=p1_w5_q0", pulses, writes,
               exp_q.size());
    end
    mem_loader_done = 1'b0;
  endtask

`ifdef TB_BOOT_TIMEOUT_EN
  task automatic test_timeout;
    int k;
    int n = -1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    writes = 0;
    request_boot(64'h1, 64'h2);
    wait_pulse("to", k);
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (error) begin
        n = i;
        break;
      end
    end
    total++;
    if (n != LoadTo) begin
      bad++;
      $display("FAIL to_latency got=%0d want=%0d", n, LoadTo);
    end
    total++;
    if ({mem_load_reset, mem_reset, load_mem, busy, dcr_write_valid} !== 5'b11000 ||
        writes != 0) begin
      bad++;
      $display("FAIL to_state got=%b_w%0d want=11000_w0",
               {mem_load_reset, mem_reset, load_mem, busy, dcr_write_valid}, writes);
    end
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_stale_done();
    test_mid_reset();
`ifdef TB_BOOT_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
